minterm_sweep_ctrl: RTL and testbench

MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

---
 rtl/minterm_sweep_pkg.sv | 19 +
 rtl/minterm_settle_timer.sv | 31 +++
 rtl/minterm_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_minterm_sweep_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/minterm_sweep_pkg.sv
// Shared types and constants for the minterm truth-table sweep controller.
// Describes a 4-input function under test and its 16-entry truth table.
package minterm_sweep_pkg;

  localparam int NUM_INPUTS = 4;
  localparam int NUM_COMBOS = 16;

  // Truth table of the standard function: minterms 0,2,4,6,9,10,13,15.
  localparam logic [NUM_COMBOS-1:0] DEF_EXP_MASK = 16'hA655;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/minterm_settle_timer.sv
// Down-counter that holds the sweep in APPLY for SETTLE_CYCLES cycles.
// expire is high during the last dwell cycle, which moves the FSM on to CAPTURE.
module minterm_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt;

  // NOTE: reset is sampled on the clock edge, and all state uses non-blocking
  // assignments so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expire = (cnt == 4'd0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Sweeps all 16 input combinations of an external 4-input function, records its
// truth table and compares it against an expected mask captured at start.
module minterm_sweep_ctrl
  import minterm_sweep_pkg::state_t;
  import minterm_sweep_pkg::ST_IDLE;
  import minterm_sweep_pkg::ST_APPLY;
  import minterm_sweep_pkg::ST_CAPTURE;
  import minterm_sweep_pkg::ST_CHECK;
  import minterm_sweep_pkg::ST_DONE;
  import minterm_sweep_pkg::NUM_INPUTS;
  import minterm_sweep_pkg::NUM_COMBOS;
#(
  parameter int                    SETTLE_CYCLES = 1,
  parameter logic [NUM_COMBOS-1:0] DEF_EXP_MASK  = minterm_sweep_pkg::DEF_EXP_MASK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_COMBOS-1:0] exp_mask,
  output logic [NUM_INPUTS-1:0] fn_in,
  input  logic                  fn_out,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_COMBOS-1:0] mask,
  output logic                  pass,
  output logic [4:0]            err_cnt,
  output logic [3:0]            err_idx
);

  state_t                state;
  logic [3:0]            idx;
  logic [NUM_COMBOS-1:0] exp_q;
  logic                  settle_load;
  logic                  settle_expire;
  logic                  mismatch;

  assign mismatch = (fn_out != exp_q[idx]);

  // The timer reloads on every edge that enters APPLY.
  assign settle_load = ((state == ST_IDLE)    && start && !abort) ||
                       ((state == ST_CAPTURE) && !abort && (idx != 4'd15));

  minterm_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (settle_load),
    .en    (state == ST_APPLY),
    .expire(settle_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      exp_q   <= '0;
      fn_in   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mask    <= '0;
      pass    <= 1'b0;
      err_cnt <= 5'd0;
      err_idx <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            exp_q   <= exp_mask;
            mask    <= '0;
            pass    <= 1'b0;
            err_cnt <= 5'd0;
            err_idx <= 4'd0;
            idx     <= 4'd0;
            fn_in   <= '0;
            busy    <= 1'b1;
            state   <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          if (abort) begin
            fn_in <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (settle_expire) begin
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (abort) begin
            // Abandon before recording this index; results stay partial.
            fn_in <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            mask[idx] <= fn_out;
            if (mismatch) begin
              err_cnt <= err_cnt + 5'd1;
              if (err_cnt == 5'd0) err_idx <= idx;
            end
            if (idx == 4'd15) begin
              fn_in <= '0;
              state <= ST_CHECK;
            end else begin
              idx   <= idx + 4'd1;
              fn_in <= idx + 4'd1;
              state <= ST_APPLY;
            end
          end
        end

        ST_CHECK: begin
          pass  <= (err_cnt == 5'd0);
          done  <= 1'b1;
          state <= ST_DONE;
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          fn_in <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Directed bench for minterm_sweep_ctrl: default-settle instance driven by a
// modelled 4-input function, plus a SETTLE_CYCLES=3 instance with fn_out tied high.
module tb_minterm_sweep_ctrl;

  localparam logic [15:0] STD_TBL = 16'hA655;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, abort_a, start_b;
  logic [15:0] exp_a, exp_b;
  logic [3:0]  fn_in_a, fn_in_b;
  logic        fn_out_a;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] mask_a, mask_b;
  logic [4:0]  err_cnt_a, err_cnt_b;
  logic [3:0]  err_idx_a, err_idx_b;
  logic [15:0] tbl;
  int          fn_mode;
  int          total = 0;
  int          bad   = 0;
  int          lat;
  int          dcnt;

  always #5 clk = ~clk;

  // Function under test: 0 = stuck-at-0, 1 = stuck-at-1, 2 = standard function.
  always_comb begin
    tbl = STD_TBL;
    if (fn_mode == 2) fn_out_a = tbl[fn_in_a];
    else              fn_out_a = (fn_mode == 1);
  end

  minterm_sweep_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .exp_mask(exp_a),
    .fn_in(fn_in_a), .fn_out(fn_out_a), .busy(busy_a), .done(done_a),
    .mask(mask_a), .pass(pass_a), .err_cnt(err_cnt_a), .err_idx(err_idx_a)
  );

  minterm_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .exp_mask(exp_b),
    .fn_in(fn_in_b), .fn_out(1'b1), .busy(busy_b), .done(done_b),
    .mask(mask_b), .pass(pass_b), .err_cnt(err_cnt_b), .err_idx(err_idx_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept start at edge 0; lat = first edge after which done is seen (-1 on timeout).
  task automatic start_and_wait(input bit sel, input logic [15:0] em, output int l);
    if (sel) begin exp_b = em; start_b = 1'b1; end
    else     begin exp_a = em; start_a = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    l = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if ((sel ? done_b : done_a) === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0;
    exp_a = 16'h0; exp_b = 16'h0; fn_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    busy_a,    0);
    check("rst_done",    done_a,    0);
    check("rst_fn_in",   fn_in_a,   0);
    check("rst_mask",    mask_a,    0);
    check("rst_pass",    pass_a,    0);
    check("rst_err_cnt", err_cnt_a, 0);
    check("rst_err_idx", err_idx_a, 0);
    check("rst_busy_b",  busy_b,    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Standard function, matching expectation.
    fn_mode = 2;
    start_and_wait(1'b0, 16'hA655, lat);
    check("s1_latency", lat,       33);
    check("s1_mask",    mask_a,    16'hA655);
    check("s1_pass",    pass_a,    1);
    check("s1_err_cnt", err_cnt_a, 0);
    check("s1_err_idx", err_idx_a, 0);
    @(posedge clk); #1;
    check("s1_done_one_cycle", done_a,  0);
    check("s1_idle_busy",      busy_a,  0);
    check("s1_idle_fn_in",     fn_in_a, 0);

    // Expectation off in bit 0.
    start_and_wait(1'b0, 16'hA654, lat);
    check("s2_latency", lat,       33);
    check("s2_mask",    mask_a,    16'hA655);
    check("s2_pass",    pass_a,    0);
    check("s2_err_cnt", err_cnt_a, 1);
    check("s2_err_idx", err_idx_a, 0);
    @(posedge clk); #1;

    // Stuck-at-0 output.
    fn_mode = 0;
    start_and_wait(1'b0, 16'hA655, lat);
    check("s3_mask",    mask_a,    16'h0000);
    check("s3_err_cnt", err_cnt_a, 8);
    check("s3_err_idx", err_idx_a, 0);
    check("s3_pass",    pass_a,    0);
    @(posedge clk); #1;

    // Longer settle, stuck-at-1 function.
    start_and_wait(1'b1, 16'hFFFF, lat);
    check("s4_latency", lat,       65);
    check("s4_mask",    mask_b,    16'hFFFF);
    check("s4_pass",    pass_b,    1);
    check("s4_err_cnt", err_cnt_b, 0);
    @(posedge clk); #1;
    check("s4_done_one_cycle", done_b, 0);

    // Abort sampled at edge 11 (APPLY of index 5): indices 0..4 recorded.
    fn_mode = 2;
    exp_a = 16'hA655; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("ab_busy",    busy_a,    0);
    check("ab_fn_in",   fn_in_a,   0);
    check("ab_mask",    mask_a,    16'h0015);
    check("ab_pass",    pass_a,    0);
    check("ab_err_cnt", err_cnt_a, 0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) dcnt++;
    end
    check("ab_no_done", dcnt,   0);
    check("ab_hold",    mask_a, 16'h0015);

    // Start re-pulsed at edges 5 and 20 while busy must be ignored.
    exp_a = 16'hA655; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 7) begin
        check("bs_fn_in_capture", fn_in_a, 3);
        check("bs_busy",          busy_a,  1);
      end
      if (done_a === 1'b1) begin
        lat = k;
        break;
      end
      start_a = (k == 4 || k == 19);
    end
    start_a = 1'b0;
    check("bs_latency", lat,    33);
    check("bs_pass",    pass_a, 1);
    @(posedge clk); #1;
    check("bs_done_one_cycle", done_a, 0);
    check("bs_no_restart",     busy_a, 0);

    // Reset sampled at edge 20 mid-sweep.
    exp_a = 16'hA654; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mr_busy",    busy_a,    0);
    check("mr_done",    done_a,    0);
    check("mr_fn_in",   fn_in_a,   0);
    check("mr_mask",    mask_a,    0);
    check("mr_pass",    pass_a,    0);
    check("mr_err_cnt", err_cnt_a, 0);
    check("mr_err_idx", err_idx_a, 0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) dcnt++;
    end
    check("mr_no_done", dcnt, 0);
    start_and_wait(1'b0, 16'hA655, lat);
    check("mr_latency", lat,       33);
    check("mr_mask2",   mask_a,    16'hA655);
    check("mr_pass2",   pass_a,    1);
    check("mr_err2",    err_cnt_a, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
